imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the `mips` core. Accepts a big-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially from word address 0 into the core's instruction memory (`U_IM`). Holds the core in reset while loading and releases it once the final word is written, so a bench or host link can drive the CPU instead of a `$readmemh` preload.

---
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the mips core.
// Takes a big-endian byte stream over valid/ready and packs it into 32-bit
// words. Each word is written to instruction memory, starting at word 0.
// The core is held in reset until the word carrying in_last has been written.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           begin a load (acted on only in IDLE or RUN)
//   in_valid/in_data/in_last/in_ready   byte stream handshake
//   im_we/im_addr/im_wdata              instruction-memory write port
//   cpu_rst         reset to the core, low only in RUN
//   busy, done      status: loading (LOAD/WRITE) / program loaded (RUN)
//   word_count      words written in the current load
//   err_align       sticky: stream ended mid-word (word zero-filled)
//   err_overflow    sticky: stream held more words than the memory depth
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  err_align,
  output logic                  err_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN} state_t;

  // word_count equal to this value means memory is full
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  in_ready_q, in_ready_d;
  logic                  im_we_q, im_we_d;
  logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
  logic [31:0]           im_wdata_q, im_wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  err_align_q, err_align_d;
  logic                  err_overflow_q, err_overflow_d;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    last_d         = last_q;
    im_we_d        = 1'b0;
    im_addr_d      = im_addr_q;
    im_wdata_d     = im_wdata_q;
    word_count_d   = word_count_q;
    err_align_d    = err_align_q;
    err_overflow_d = err_overflow_q;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          state_d        = S_LOAD;
          idx_d          = 2'd0;
          last_d         = 1'b0;
          word_count_d   = '0;
          err_align_d    = 1'b0;
          err_overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          // Byte 0 overwrites the whole word, so a short final word is
          // zero-filled below the bytes actually received.
          case (idx_q)
            2'd0:    im_wdata_d = {in_data, 24'h0};
            2'd1:    im_wdata_d[23:16] = in_data;
            2'd2:    im_wdata_d[15:8]  = in_data;
            default: im_wdata_d[7:0]   = in_data;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3 || in_last) begin
            state_d   = S_WRITE;
            last_d    = in_last;
            im_we_d   = (word_count_q != DEPTH);
            im_addr_d = word_count_q[ADDR_WIDTH-1:0];
            if (in_last && idx_q != 2'd3) err_align_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        idx_d = 2'd0;
        // Past the end of memory: drop the word and keep counting frozen.
        if (word_count_q == DEPTH) err_overflow_d = 1'b1;
        else                       word_count_d   = word_count_q + 1'b1;
        state_d = last_q ? S_RUN : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next state's decode.
    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d     = (state_d == S_RUN);
    cpu_rst_d  = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= 2'd0;
      last_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      im_we_q        <= 1'b0;
      im_addr_q      <= '0;
      im_wdata_q     <= 32'h0;
      cpu_rst_q      <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      word_count_q   <= '0;
      err_align_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      last_q         <= last_d;
      in_ready_q     <= in_ready_d;
      im_we_q        <= im_we_d;
      im_addr_q      <= im_addr_d;
      im_wdata_q     <= im_wdata_d;
      cpu_rst_q      <= cpu_rst_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      word_count_q   <= word_count_d;
      err_align_q    <= err_align_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign word_count   = word_count_q;
  assign err_align    = err_align_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a cycle table for a continuous three-word load, then
// directed sequences for misalignment, reload, stalls, overflow and reset.
// A second instance with ADDR_WIDTH=2 shares the stimulus for overflow.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic       in_last = 1'b0;

  logic        in_ready, im_we, cpu_rst, busy, done, err_align, err_overflow;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] word_count;

  logic        in_ready2, im_we2, cpu_rst2, busy2, done2, err_align2, err_overflow2;
  logic [1:0]  im_addr2;
  logic [31:0] im_wdata2;
  logic [2:0]  word_count2;

  imem_loader #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .word_count(word_count), .err_align(err_align), .err_overflow(err_overflow)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready2), .im_we(im_we2), .im_addr(im_addr2),
    .im_wdata(im_wdata2), .cpu_rst(cpu_rst2), .busy(busy2), .done(done2),
    .word_count(word_count2), .err_align(err_align2), .err_overflow(err_overflow2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {logic [9:0] a; logic [31:0] w;} wr_t;
  wr_t wq[$];
  wr_t wq2[$];

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (im_we)  wq.push_back({im_addr, im_wdata});
    if (im_we2) wq2.push_back({8'h0, im_addr2, im_wdata2});
  end

  typedef struct {
    logic st, vl; logic [7:0] d; logic lst;
    logic rdy, we; logic [9:0] a; logic [31:0] w;
    logic crst, bsy, dn; logic [10:0] wc;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(logic st, logic vl, logic [7:0] d, logic lst,
                              logic rdy, logic we, logic [9:0] a, logic [31:0] w,
                              logic crst, logic bsy, logic dn, logic [10:0] wc);
    vec_t v;
    v.st = st; v.vl = vl; v.d = d; v.lst = lst;
    v.rdy = rdy; v.we = we; v.a = a; v.w = w;
    v.crst = crst; v.bsy = bsy; v.dn = dn; v.wc = wc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic lst);
    bit ok = 0;
    in_valid = 1'b1; in_data = b; in_last = lst;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL handshake: byte %0h never accepted", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic lst);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   lst);
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && !done; i++) step();
  endtask

  task automatic chk_wr(input string nm, input int i, input logic [9:0] a, input logic [31:0] w);
    if (i < wq.size()) chk(nm, {22'h0, wq[i].a, wq[i].w}, {22'h0, a, w});
    else begin
      tests++; fails++;
      $display("FAIL %s: write %0d missing, got %0d writes", nm, i, wq.size());
    end
  endtask

  task automatic chk_wr2(input string nm, input int i, input logic [9:0] a, input logic [31:0] w);
    if (i < wq2.size()) chk(nm, {22'h0, wq2[i].a, wq2[i].w}, {22'h0, a, w});
    else begin
      tests++; fails++;
      $display("FAIL %s: write %0d missing, got %0d writes", nm, i, wq2.size());
    end
  endtask

  function automatic logic [63:0] all_out();
    return {4'h0, in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done,
            word_count, err_align, err_overflow};
  endfunction

  // Reset image: only cpu_rst is high.
  localparam logic [63:0] RST_IMG = 64'h1 << 15;

  logic [7:0] sb[8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h0C};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Continuous three-word load; the byte offered during WRITE is repeated.
    tv[0]  = mk(1,0,8'h00,0, 1,0,10'd0,32'h0,        1,1,0,11'd0);
    tv[1]  = mk(0,1,8'h20,0, 1,0,10'd0,32'h0,        1,1,0,11'd0);
    tv[2]  = mk(0,1,8'h01,0, 1,0,10'd0,32'h0,        1,1,0,11'd0);
    tv[3]  = mk(0,1,8'h00,0, 1,0,10'd0,32'h0,        1,1,0,11'd0);
    tv[4]  = mk(0,1,8'h05,0, 0,1,10'd0,32'h20010005, 1,1,0,11'd0);
    tv[5]  = mk(0,1,8'h20,0, 1,0,10'd0,32'h0,        1,1,0,11'd1);
    tv[6]  = mk(0,1,8'h20,0, 1,0,10'd0,32'h0,        1,1,0,11'd1);
    tv[7]  = mk(0,1,8'h02,0, 1,0,10'd0,32'h0,        1,1,0,11'd1);
    tv[8]  = mk(0,1,8'h00,0, 1,0,10'd0,32'h0,        1,1,0,11'd1);
    tv[9]  = mk(0,1,8'h0C,0, 0,1,10'd1,32'h2002000C, 1,1,0,11'd1);
    tv[10] = mk(0,1,8'hAC,0, 1,0,10'd0,32'h0,        1,1,0,11'd2);
    tv[11] = mk(0,1,8'hAC,0, 1,0,10'd0,32'h0,        1,1,0,11'd2);
    tv[12] = mk(0,1,8'h01,0, 1,0,10'd0,32'h0,        1,1,0,11'd2);
    tv[13] = mk(0,1,8'h00,0, 1,0,10'd0,32'h0,        1,1,0,11'd2);
    tv[14] = mk(0,1,8'h50,1, 0,1,10'd2,32'hAC010050, 1,1,0,11'd2);
    tv[15] = mk(0,0,8'h00,0, 0,0,10'd0,32'h0,        0,0,1,11'd3);

    #12;
    chk("reset_values", all_out(), RST_IMG);
    chk("reset_dut2", {cpu_rst2, busy2, done2, word_count2, err_overflow2}, 7'b1000000);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- table: three-word continuous load
    wq.delete(); wq2.delete();
    for (int i = 0; i < 16; i++) begin
      start = tv[i].st; in_valid = tv[i].vl; in_data = tv[i].d; in_last = tv[i].lst;
      step();
      chk($sformatf("vec%0d", i),
          {in_ready, im_we, cpu_rst, busy, done, word_count, err_align, err_overflow},
          {tv[i].rdy, tv[i].we, tv[i].crst, tv[i].bsy, tv[i].dn, tv[i].wc, 2'b00});
      if (tv[i].we)
        chk($sformatf("vec%0d_wr", i), {im_addr, im_wdata}, {tv[i].a, tv[i].w});
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("three_nwr", wq.size(), 3);
    chk_wr("three_wr2", 2, 10'd2, 32'hAC010050);

    // ---- misaligned end
    wq.delete();
    do_start();
    send_word(32'h11223344, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    wait_done();
    chk("mis_done", done, 1);
    chk("mis_wr1", wq.size() > 1 ? {wq[1].a, wq[1].w} : 42'h0, {10'd1, 32'hAABB0000});
    chk("mis_err_align", err_align, 1);
    chk("mis_wc", word_count, 2);

    // ---- reload from RUN with err_align set
    wq.delete();
    do_start();
    chk("reload_state", {cpu_rst, done, busy, word_count, err_align, err_overflow},
        {3'b101, 11'd0, 2'b00});
    send_word(32'hDEADBEEF, 1'b1);
    wait_done();
    chk("reload_nwr", wq.size(), 1);
    chk_wr("reload_wr0", 0, 10'd0, 32'hDEADBEEF);

    // ---- stalls of three cycles between bytes, start pulsed mid-load
    wq.delete();
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(sb[i], i == 7);
      if (i < 7) begin
        start = (i == 1); step(); start = 1'b0;
        step(); step();
      end
    end
    wait_done();
    chk("stall_nwr", wq.size(), 2);
    chk_wr("stall_wr0", 0, 10'd0, 32'h20010005);
    chk_wr("stall_wr1", 1, 10'd1, 32'h2002000C);
    chk("stall_wc", word_count, 2);

    // ---- overflow on the 4-word instance
    wq.delete(); wq2.delete();
    do_start();
    for (int k = 0; k < 6; k++) send_word(32'h01020300 + k, k == 5);
    wait_done();
    chk("ovf_nwr", wq2.size(), 4);
    for (int k = 0; k < 4; k++)
      chk_wr2($sformatf("ovf_wr%0d", k), k, 10'(k), 32'h01020300 + k);
    chk("ovf_flags", {done2, err_overflow2, err_align2, word_count2}, {3'b110, 3'd4});
    chk("big_nwr", wq.size(), 6);
    chk("big_state", {err_overflow, word_count}, {1'b0, 11'd6});

    // ---- reset in the middle of the second word
    do_start();
    send_word(32'h11111111, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    #3 rst = 1'b1;
    #1 chk("rst_mid_async", all_out(), RST_IMG);
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete();
    do_start();
    send_word(32'hCAFEF00D, 1'b1);
    wait_done();
    chk("rst_nwr", wq.size(), 1);
    chk_wr("rst_wr0", 0, 10'd0, 32'hCAFEF00D);
    chk("rst_wc", word_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
